// File: rtl/wasm_pkg.sv
// Shared types for the wasm boot path: boot FSM states and the
// host-visible boot status codes.
package wasm_pkg;

  typedef enum logic [2:0] {
    BS_NONE      = 3'd0,
    BS_OK        = 3'd1,
    BS_LOAD_ERR  = 3'd2,
    BS_TIMEOUT   = 3'd3,
    BS_NO_FUNC   = 3'd4,
    BS_BAD_START = 3'd5,
    BS_TRAP      = 3'd6,
    BS_ABORTED   = 3'd7
  } boot_status_t;

  typedef logic [3:0] boot_state_t;

  localparam boot_state_t S_IDLE      = 4'd0;
  localparam boot_state_t S_LDR_RESET = 4'd1;
  localparam boot_state_t S_LOAD_REQ  = 4'd2;
  localparam boot_state_t S_LOAD_WAIT = 4'd3;
  localparam boot_state_t S_RESOLVE   = 4'd4;
  localparam boot_state_t S_CPU_START = 4'd5;
  localparam boot_state_t S_RUN       = 4'd6;
  localparam boot_state_t S_HALTED    = 4'd7;
  localparam boot_state_t S_FAULT     = 4'd8;

  localparam logic [31:0] NO_START_IDX  = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_MOD_SIZE  = 32'd8;
  localparam logic [31:0] DONE_MASK_CYC = 32'd2;

endpackage

// File: rtl/wasm_boot_ctrl.sv
// Boot sequencer: resets/starts the loader, validates its results,
// then launches and monitors the CPU, latching one status code.
module wasm_boot_ctrl
  import wasm_pkg::*;
#(
  parameter logic [31:0] LOAD_TIMEOUT   = 32'd1048576,
  parameter int          LDR_RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_boot,
  input  logic        host_abort,
  input  logic [31:0] host_module_size,
  output logic        ldr_rst_n,
  output logic        ldr_start,
  output logic [31:0] ldr_module_size,
  input  logic        ldr_done,
  input  logic        ldr_error,
  input  logic [15:0] ldr_num_functions,
  input  logic [31:0] ldr_start_func_idx,
  output logic        cpu_rst_n,
  output logic        cpu_run,
  output logic [15:0] cpu_entry_idx,
  input  logic        cpu_halted,
  input  logic        cpu_trap,
  input  logic [7:0]  cpu_trap_code,
  output logic        boot_busy,
  output logic [2:0]  boot_status,
  output logic [7:0]  trap_code,
  output logic [31:0] run_cycles
);

  localparam logic [31:0] RST_LAST = 32'(LDR_RST_CYCLES - 1);

  boot_state_t  state_q, state_d;
  boot_status_t status_q, status_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  size_q, size_d;
  logic [31:0]  run_q, run_d;
  logic [15:0]  entry_q, entry_d;
  logic [7:0]   trap_q, trap_d;
  logic         ldr_rst_n_q, ldr_rst_n_d;
  logic         ldr_start_q, ldr_start_d;
  logic         cpu_rst_n_q, cpu_rst_n_d;
  logic         cpu_run_q, cpu_run_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    size_d   = size_q;
    run_d    = run_q;
    entry_d  = entry_q;
    trap_d   = trap_q;
    if (host_abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      status_d = BS_ABORTED;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED, S_FAULT: begin
          if (host_boot) begin
            size_d   = host_module_size;
            run_d    = '0;
            trap_d   = '0;
            status_d = BS_NONE;
            if (host_module_size < MIN_MOD_SIZE) begin
              state_d  = S_FAULT;
              status_d = BS_LOAD_ERR;
            end else begin
              state_d = S_LDR_RESET;
            end
          end
        end
        S_LDR_RESET: begin
          if (cnt_q >= RST_LAST) state_d = S_LOAD_REQ;
        end
        S_LOAD_REQ: state_d = S_LOAD_WAIT;
        S_LOAD_WAIT: begin
          // done is stale until the loader clears it after start
          if (ldr_done && cnt_q >= DONE_MASK_CYC) begin
            if (ldr_error) begin
              state_d  = S_FAULT;
              status_d = BS_LOAD_ERR;
            end else begin
              state_d = S_RESOLVE;
            end
          end else if (cnt_q + 32'd1 >= LOAD_TIMEOUT) begin
            state_d  = S_FAULT;
            status_d = BS_TIMEOUT;
          end
        end
        S_RESOLVE: begin
          if (ldr_num_functions == 16'd0) begin
            state_d  = S_FAULT;
            status_d = BS_NO_FUNC;
          end else if (ldr_start_func_idx == NO_START_IDX) begin
            entry_d = '0;
            state_d = S_CPU_START;
          end else if (ldr_start_func_idx >= {16'd0, ldr_num_functions}) begin
            state_d  = S_FAULT;
            status_d = BS_BAD_START;
          end else begin
            entry_d = ldr_start_func_idx[15:0];
            state_d = S_CPU_START;
          end
        end
        S_CPU_START: state_d = S_RUN;
        S_RUN: begin
          if (run_q != 32'hFFFF_FFFF) run_d = run_q + 32'd1;
          if (cpu_trap) begin
            state_d  = S_FAULT;
            status_d = BS_TRAP;
            trap_d   = cpu_trap_code;
          end else if (cpu_halted) begin
            state_d  = S_HALTED;
            status_d = BS_OK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_LDR_RESET || state_q == S_LOAD_WAIT))
      cnt_d = cnt_q + 32'd1;
    // loader reset is held released after a load so results stay readable
    ldr_rst_n_d = ldr_rst_n_q;
    if (state_d == S_LDR_RESET) ldr_rst_n_d = 1'b0;
    if (state_d == S_LOAD_REQ)  ldr_rst_n_d = 1'b1;
    ldr_start_d = (state_d == S_LOAD_REQ);
    cpu_run_d   = (state_d == S_CPU_START);
    cpu_rst_n_d = (state_d == S_CPU_START) ||
                  (state_d == S_RUN) ||
                  (state_d == S_HALTED);
    busy_d      = !((state_d == S_IDLE) ||
                    (state_d == S_HALTED) ||
                    (state_d == S_FAULT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      status_q    <= BS_NONE;
      cnt_q       <= '0;
      size_q      <= '0;
      run_q       <= '0;
      entry_q     <= '0;
      trap_q      <= '0;
      ldr_rst_n_q <= 1'b0;
      ldr_start_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      run_q       <= run_d;
      entry_q     <= entry_d;
      trap_q      <= trap_d;
      ldr_rst_n_q <= ldr_rst_n_d;
      ldr_start_q <= ldr_start_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      cpu_run_q   <= cpu_run_d;
      busy_q      <= busy_d;
    end
  end

  assign ldr_rst_n       = ldr_rst_n_q;
  assign ldr_start       = ldr_start_q;
  assign ldr_module_size = size_q;
  assign cpu_rst_n       = cpu_rst_n_q;
  assign cpu_run         = cpu_run_q;
  assign cpu_entry_idx   = entry_q;
  assign boot_busy       = busy_q;
  assign boot_status     = status_q;
  assign trap_code       = trap_q;
  assign run_cycles      = run_q;

endmodule

// File: tb/tb_wasm_boot_ctrl.sv
// Directed scoreboard bench for wasm_boot_ctrl.
// Expected values are queued at stimulus time and popped at observation.
module tb_wasm_boot_ctrl;
  import wasm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_boot = 1'b0;
  logic        host_abort = 1'b0;
  logic [31:0] host_module_size = '0;
  logic        ldr_rst_n;
  logic        ldr_start;
  logic [31:0] ldr_module_size;
  logic        ldr_done = 1'b0;
  logic        ldr_error = 1'b0;
  logic [15:0] ldr_num_functions = '0;
  logic [31:0] ldr_start_func_idx = '0;
  logic        cpu_rst_n;
  logic        cpu_run;
  logic [15:0] cpu_entry_idx;
  logic        cpu_halted = 1'b0;
  logic        cpu_trap = 1'b0;
  logic [7:0]  cpu_trap_code = '0;
  logic        boot_busy;
  logic [2:0]  boot_status;
  logic [7:0]  trap_code;
  logic [31:0] run_cycles;

  always #5 clk = ~clk;

  wasm_boot_ctrl #(
    .LOAD_TIMEOUT  (32'd150),
    .LDR_RST_CYCLES(2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_boot         (host_boot),
    .host_abort        (host_abort),
    .host_module_size  (host_module_size),
    .ldr_rst_n         (ldr_rst_n),
    .ldr_start         (ldr_start),
    .ldr_module_size   (ldr_module_size),
    .ldr_done          (ldr_done),
    .ldr_error         (ldr_error),
    .ldr_num_functions (ldr_num_functions),
    .ldr_start_func_idx(ldr_start_func_idx),
    .cpu_rst_n         (cpu_rst_n),
    .cpu_run           (cpu_run),
    .cpu_entry_idx     (cpu_entry_idx),
    .cpu_halted        (cpu_halted),
    .cpu_trap          (cpu_trap),
    .cpu_trap_code     (cpu_trap_code),
    .boot_busy         (boot_busy),
    .boot_status       (boot_status),
    .trap_code         (trap_code),
    .run_cycles        (run_cycles)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_boot(input logic [31:0] size);
    host_module_size = size;
    host_boot = 1'b1;
    tick();
    host_boot = 1'b0;
  endtask

  task automatic wait_end(input int max, output int n, output bit saw);
    n = 0;
    saw = 1'b0;
    while (boot_busy && !cpu_run && n < max) begin
      tick();
      n++;
      if (cpu_rst_n) saw = 1'b1;
    end
    push("wait_bound", 32'd1);
    chk(32'(n < max));
  endtask

  logic [31:0] t_start [8] = '{32'hFFFF_FFFF, 32'd5, 32'd3, 32'd2,
                               32'd0, 32'hFFFF_FFFF, 32'h0001_0001, 32'd0};
  logic [15:0] t_num   [8] = '{16'd3, 16'd3, 16'd3, 16'd3,
                               16'd0, 16'd0, 16'd3, 16'd1};
  logic [2:0]  t_stat  [8] = '{3'd1, 3'd5, 3'd5, 3'd1,
                               3'd4, 3'd4, 3'd5, 3'd1};
  logic [15:0] t_entry [8] = '{16'd0, 16'd0, 16'd0, 16'd2,
                               16'd0, 16'd0, 16'd0, 16'd0};

  initial begin
    int n;
    bit saw;

    #3;
    push("rst_outs", 32'd0);
    chk({ldr_rst_n, ldr_start, cpu_rst_n, cpu_run, boot_busy,
         boot_status, trap_code});
    push("rst_run_cycles", 32'd0);
    chk(run_cycles);
    push("rst_size_entry", 32'd0);
    chk(ldr_module_size | {16'd0, cpu_entry_idx});
    tick();
    rst_n = 1'b1;
    tick();

    // nominal boot, done after 100 cycles, no start func
    do_boot(32'd64);
    push("boot_busy", 32'd1);
    chk(boot_busy);
    push("ldr_rst_lo", 32'd0);
    chk(ldr_rst_n);
    tick();
    push("start_early", 32'd0);
    chk(ldr_start);
    tick();
    push("ldr_start", 32'd1);
    chk(ldr_start);
    push("ldr_rst_hi", 32'd1);
    chk(ldr_rst_n);
    push("ldr_size", 32'd64);
    chk(ldr_module_size);
    tick();
    push("start_pulse", 32'd0);
    chk(ldr_start);
    repeat (99) tick();
    ldr_start_func_idx = 32'hFFFF_FFFF;
    ldr_num_functions = 16'd3;
    ldr_done = 1'b1;
    tick();
    push("run_early", 32'd0);
    chk(cpu_run);
    tick();
    push("cpu_run", 32'd1);
    chk(cpu_run);
    push("entry_none", 32'd0);
    chk(cpu_entry_idx);
    push("cpu_rst_hi", 32'd1);
    chk(cpu_rst_n);
    tick();
    push("run_pulse", 32'd0);
    chk(cpu_run);
    repeat (8) tick();
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    push("halt_status", 32'(BS_OK));
    chk(boot_status);
    push("halt_busy", 32'd0);
    chk(boot_busy);
    push("halt_cpu_rst", 32'd1);
    chk(cpu_rst_n);
    push("run_cycles", 32'd9);
    chk(run_cycles);

    // stale done held from previous load, then error
    do_boot(32'd64);
    push("status_clr", 32'(BS_NONE));
    chk(boot_status);
    push("run_clr", 32'd0);
    chk(run_cycles);
    repeat (3) tick();
    tick();
    ldr_error = 1'b1;
    tick();
    push("stale_busy", 32'd1);
    chk(boot_busy);
    push("stale_status", 32'(BS_NONE));
    chk(boot_status);
    tick();
    push("ldr_err", 32'(BS_LOAD_ERR));
    chk(boot_status);
    push("err_ldr_rst", 32'd1);
    chk(ldr_rst_n);
    push("err_cpu_rst", 32'd0);
    chk(cpu_rst_n);
    ldr_error = 1'b0;

    // resolve table
    for (int i = 0; i < 8; i++) begin
      ldr_start_func_idx = t_start[i];
      ldr_num_functions = t_num[i];
      ldr_done = 1'b1;
      do_boot(32'd64);
      wait_end(40, n, saw);
      if (t_stat[i] == 3'd1) begin
        push($sformatf("entry_%0d", i), 32'(t_entry[i]));
        chk(cpu_entry_idx);
        push($sformatf("run_%0d", i), 32'd1);
        chk(cpu_run);
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        push($sformatf("abort_%0d", i), 32'(BS_ABORTED));
        chk(boot_status);
      end else begin
        push($sformatf("res_status_%0d", i), 32'(t_stat[i]));
        chk(boot_status);
        push($sformatf("res_cpu_rst_%0d", i), 32'd0);
        chk(32'(saw));
      end
    end

    // module too small, then minimum size
    do_boot(32'd7);
    push("small_status", 32'(BS_LOAD_ERR));
    chk(boot_status);
    push("small_busy", 32'd0);
    chk(boot_busy);
    saw = 1'b0;
    repeat (4) begin
      tick();
      if (ldr_start) saw = 1'b1;
    end
    push("small_no_start", 32'd0);
    chk(32'(saw));
    do_boot(32'd8);
    push("min_busy", 32'd1);
    chk(boot_busy);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;

    // load timeout, with a dropped boot while busy
    ldr_done = 1'b0;
    do_boot(32'd64);
    repeat (3) tick();
    host_module_size = 32'd100;
    host_boot = 1'b1;
    tick();
    host_boot = 1'b0;
    push("busy_boot_drop", 32'd64);
    chk(ldr_module_size);
    wait_end(400, n, saw);
    push("tmo_cycles", 32'd150);
    chk(32'(n + 1));
    push("tmo_status", 32'(BS_TIMEOUT));
    chk(boot_status);

    // abort beats boot in LOAD_WAIT
    do_boot(32'd64);
    repeat (8) tick();
    host_abort = 1'b1;
    host_boot = 1'b1;
    tick();
    host_abort = 1'b0;
    host_boot = 1'b0;
    push("abort_status", 32'(BS_ABORTED));
    chk(boot_status);
    push("abort_outs", 32'd0);
    chk({boot_busy, cpu_rst_n, ldr_start});
    tick();
    push("abort_idle", 32'd0);
    chk(boot_busy);

    // trap and halt together
    ldr_start_func_idx = 32'd2;
    ldr_num_functions = 16'd3;
    ldr_done = 1'b1;
    do_boot(32'd64);
    wait_end(40, n, saw);
    tick();
    tick();
    cpu_trap = 1'b1;
    cpu_halted = 1'b1;
    cpu_trap_code = 8'h0A;
    tick();
    cpu_trap = 1'b0;
    cpu_halted = 1'b0;
    cpu_trap_code = 8'h00;
    push("trap_status", 32'(BS_TRAP));
    chk(boot_status);
    push("trap_code", 32'h0A);
    chk(trap_code);
    push("trap_cpu_rst", 32'd0);
    chk(cpu_rst_n);

    // async reset mid-RUN
    do_boot(32'd64);
    push("trap_clr", 32'd0);
    chk(trap_code);
    wait_end(40, n, saw);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_outs", 32'd0);
    chk({ldr_rst_n, ldr_start, cpu_rst_n, cpu_run, boot_busy,
         boot_status, trap_code});
    push("arst_run_cycles", 32'd0);
    chk(run_cycles);
    push("arst_size_entry", 32'd0);
    chk(ldr_module_size | {16'd0, cpu_entry_idx});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
